// File: rtl/hazard_control.sv
// Hazard and pipeline-control unit: stalls, flush strobes, PC enable, sticky halt.
// Optional perf counters enabled by defining HAZARD_PERF_EN.
package hazard_pkg;
  typedef struct packed {
    logic ifidStall;
    logic idexStall;
    logic allStall;
  } pStall_t;
endpackage

module hazard_control
  import hazard_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_usesRt,
  input  logic        id_jump,
  input  logic        idex_memRead,
  input  logic [4:0]  idex_wsel,
  input  logic        ex_branchTaken,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        exmem_halt,
  output pStall_t     stall,
  output logic        ifidFlush,
  output logic        idexFlush,
  output logic        exmemFlush,
  output logic        pcWEN,
  output logic        halt,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
);

  typedef enum logic [1:0] {
    RUN,
    MEMWAIT,
    HALT
  } state_t;

  state_t state, nextState;

  logic memPend;
  logic loadUse;
  logic adv;

  assign memPend = (exmem_dREN | exmem_dWEN) & ~dhit;

  assign loadUse = idex_memRead
                 & (idex_wsel != 5'd0)
                 & ((idex_wsel == ifid_rs)
                 | (ifid_usesRt & (idex_wsel == ifid_rt)));

  // Only consulted on paths where allStall is already 0.
  assign adv = ihit | dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    stall      = '0;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    pcWEN      = 1'b0;
    halt       = 1'b0;
    nextState  = state;
    unique case (state)
      HALT: begin
        stall.allStall = 1'b1;
        halt           = 1'b1;
        exmemFlush     = 1'b1;
      end
      RUN, MEMWAIT: begin
        if (state == MEMWAIT && !dhit) begin
          stall.allStall = 1'b1;
        end else begin
          nextState = RUN;
          if (exmem_halt) begin
            stall.allStall = 1'b1;
            nextState      = HALT;
          end else if (memPend) begin
            stall.allStall = 1'b1;
            nextState      = MEMWAIT;
          end else if (ex_branchTaken && adv) begin
            ifidFlush = 1'b1;
            idexFlush = 1'b1;
            pcWEN     = 1'b1;
          end else if (loadUse) begin
            stall.idexStall = 1'b1;
          end else if (id_jump && adv) begin
            ifidFlush = 1'b1;
            pcWEN     = 1'b1;
          end else begin
            pcWEN = ihit;
          end
        end
      end
      default: begin
        nextState = RUN;
      end
    endcase
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] sCnt, fCnt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sCnt <= '0;
      fCnt <= '0;
    end else begin
      if ((|stall) && state != HALT) begin
        sCnt <= sCnt + 32'd1;
      end
      if (ifidFlush | idexFlush) begin
        fCnt <= fCnt + 32'd1;
      end
    end
  end

  assign stallCount = sCnt;
  assign flushCount = fCnt;
`else
  assign stallCount = '0;
  assign flushCount = '0;
`endif

endmodule

// File: doc/hazard_control.md
# hazard_control

Hazard and pipeline-control unit for the five-stage multicore datapath. It drives the stall bundle (`pStall_t`: `ifidStall`, `idexStall`, `allStall`) and the `ifidFlush`, `idexFlush` and `exmemFlush` strobes consumed by the pipeline register block. It also drives the PC write enable and the sticky halt. A small FSM freezes the pipeline across data-memory waits and halt, and gates flushes so they act only on a real pipeline advance.

## Interface
Parameters:
- none

Ports:
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `ihit`, `dhit` in 1 each: cache hit pulses, one cycle each.
- `ifid_rs`, `ifid_rt` in 5 each: source registers of the instruction in ID.
- `ifid_usesRt` in 1: the ID instruction reads rt.
- `id_jump` in 1: a J/JAL instruction is in ID.
- `idex_memRead` in 1: a load is in EX.
- `idex_wsel` in 5: destination register of the EX instruction.
- `ex_branchTaken` in 1: a branch or JR in EX resolved as a redirect.
- `exmem_dREN`, `exmem_dWEN` in 1 each: a memory operation is in MEM.
- `exmem_halt` in 1: a HALT is in MEM.
- `stall` out `pStall_t`: stall bundle.
- `ifidFlush`, `idexFlush`, `exmemFlush` out 1 each: flush strobes.
- `pcWEN` out 1: PC update enable.
- `halt` out 1: sticky halt.
- `stallCount`, `flushCount` out 32 each: performance counters.

## Operation
- FSM states: RUN, MEMWAIT, HALT. Reset state is RUN.
- `memPend` = (`exmem_dREN` | `exmem_dWEN`) & !`dhit`.
- `loadUse` = `idex_memRead` & (`idex_wsel` != 0) & ((`idex_wsel` == `ifid_rs`) | (`ifid_usesRt` & `idex_wsel` == `ifid_rt`)).
- `adv` = (`ihit` | `dhit`) & !`allStall`.

RUN state:
- If `exmem_halt`: `allStall`=1, next state HALT.
- Else if `memPend`: `allStall`=1, next state MEMWAIT.
- Else, in priority order:
  - `ex_branchTaken` & `adv`: `ifidFlush`=`idexFlush`=1, `pcWEN`=1. `loadUse` and `id_jump` are ignored because those instructions are wrong-path.
  - `loadUse`: `idexStall`=1, `pcWEN`=0. Inserts exactly one bubble.
  - `id_jump` & `adv`: `ifidFlush`=1, `pcWEN`=1.
  - Otherwise: `pcWEN`=`ihit`.

MEMWAIT state:
- `allStall`=1 every cycle until `dhit`.
- On the `dhit` cycle: `allStall`=0, and the RUN rules above apply in that same cycle. Next state is RUN.
- All flushes and `pcWEN` are 0 while `allStall`=1.

HALT state:
- Absorbing.
- `allStall`=1, `halt`=1, `exmemFlush`=1, `pcWEN`=0.
- Only `nRST` exits.

Other outputs:
- `ifidStall` is never asserted. It is reserved and tied to 0.
- `halt` is 0 in RUN and MEMWAIT.

## Timing
- All stall and flush outputs are combinational from state plus inputs, so they are seen by the same clock edge.
- State and counters are registered.
- Reset values:
  - state is RUN, `halt`=0, counters are 0.
  - With idle inputs, all stall bits, flushes and `pcWEN` are 0.
- Load-use costs exactly 1 cycle. On the next edge the load moves to MEM and `loadUse` drops.
- A taken branch costs 2 flushed slots. A jump costs 1 flushed slot.
- Simultaneous events:
  - `memPend` with `ex_branchTaken`: stall wins. The flush fires on the first advancing cycle after `dhit`.
  - `exmem_halt` with `memPend`: HALT wins.
  - A flush is never emitted on a cycle with `adv`=0, so a pending redirect is not lost while `ihit` is low.
- Reset mid-operation (for example in MEMWAIT): immediately returns to RUN with outputs cleared.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stallCount` increments on every cycle where any stall bit is 1 and state is not HALT.
  - `flushCount` increments on every cycle where `ifidFlush` | `idexFlush` is 1.
  - Both wrap at 2^32.
- `HAZARD_PERF_EN` undefined: both counters are constant 0 and no counter flops are inferred.

## Test plan
- Load-use: lw $2 in EX, add rs=$2 in ID, `ihit`=1. Required: `idexStall`=1 and `pcWEN`=0 for exactly 1 cycle, then 0. No stall when `idex_wsel`=0.
- Memory wait: lw in MEM, `dhit` low for 4 cycles. Required: `allStall`=1 for 4 cycles and state MEMWAIT. On the `dhit` cycle `allStall`=0, then RUN.
- Branch during memory wait: `ex_branchTaken`=1 with `memPend` for 3 cycles. Required: no flush during the wait. `ifidFlush`=`idexFlush`=1 and `pcWEN`=1 on the first cycle with `dhit`.
- Jump with `ihit` low for 2 cycles then high. Required: `ifidFlush`=1 only on the `ihit` cycle.
- HALT: `exmem_halt`=1. Required: `halt`=1, `allStall`=1 and `exmemFlush`=1 held indefinitely. Pulsing `nRST` low returns all outputs to 0.
- Perf counters, with `HAZARD_PERF_EN`: 1 load-use, 4-cycle memory wait and 1 branch. Required: `stallCount`=5, `flushCount`=1. Without the macro both read 0.
